// File: rtl/relogio_pkg.sv
// relogio_pkg: shared widths, limits and state encoding for the clock time-base.
package relogio_pkg;
    localparam int TIME_W = 6;
    localparam logic [TIME_W-1:0] SEG_MAX = 6'd59;
    localparam logic [TIME_W-1:0] MIN_MAX = 6'd59;
    typedef enum logic {RUN, SET} relogio_state_t;
endpackage

// File: rtl/bin2bcd.sv
// bin2bcd: combinational 0-59 binary to two-digit BCD (tens in [7:4], units in [3:0]).
module bin2bcd
    import relogio_pkg::*;
(
    input  logic [TIME_W-1:0] bin_i,
    output logic [7:0]        bcd_o
);
    logic [TIME_W-1:0] tens, units;
    always_comb begin
        tens  = bin_i / 6'd10;
        units = bin_i % 6'd10;
        bcd_o = {tens[3:0], units[3:0]};
    end
endmodule

// File: rtl/minutos_ctrl.sv
// minutos_ctrl: 1 s prescaler, seconds/minutes counters, hour-increment pulse and SET-mode adjust.
// Optional BCD outputs seg_bcd_o/min_bcd_o are built only when RELOGIO_BCD_EN is defined.
module minutos_ctrl
    import relogio_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              set_mode_i,
    input  logic              adj_min_i,
    input  logic              adj_hora_i,
    output logic [TIME_W-1:0] segundos_o,
    output logic [TIME_W-1:0] minutos_o,
    output logic              tick_seg_o,
    output logic              inc_hora_o
`ifdef RELOGIO_BCD_EN
    ,
    output logic [7:0]        seg_bcd_o,
    output logic [7:0]        min_bcd_o
`endif
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);

    relogio_state_t    state_q, state_d;
    logic [PW-1:0]     presc_q, presc_d;
    logic [TIME_W-1:0] seg_q, seg_d, min_q, min_d;
    logic              tick_q, tick_d, inc_q, inc_d;
    logic              in_set, force0, counting, term, min_step;

    always_comb begin
        state_d  = set_mode_i ? SET : RUN;
        in_set   = state_q == SET;
        // The RUN->SET cycle already counts as SET, so a coincident terminal tick is dropped.
        force0   = in_set || set_mode_i;
        counting = !force0 && en_i;
        term     = counting && presc_q == PMAX;
        presc_d  = force0 ? '0 : term ? '0 : counting ? presc_q + 1'b1 : presc_q;
        seg_d    = force0 ? '0 : term ? (seg_q == SEG_MAX ? '0 : seg_q + 6'd1) : seg_q;
        min_step = (term && seg_q == SEG_MAX) || (in_set && adj_min_i);
        min_d    = min_step ? (min_q == MIN_MAX ? '0 : min_q + 6'd1) : min_q;
        tick_d   = term;
        inc_d    = (term && seg_q == SEG_MAX && min_q == MIN_MAX) || (in_set && adj_hora_i);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= RUN;
            presc_q <= '0;
            seg_q   <= '0;
            min_q   <= '0;
            tick_q  <= 1'b0;
            inc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            seg_q   <= seg_d;
            min_q   <= min_d;
            tick_q  <= tick_d;
            inc_q   <= inc_d;
        end
    end

    assign segundos_o = seg_q;
    assign minutos_o  = min_q;
    assign tick_seg_o = tick_q;
    assign inc_hora_o = inc_q;

`ifdef RELOGIO_BCD_EN
    bin2bcd u_seg_bcd (.bin_i(seg_q), .bcd_o(seg_bcd_o));
    bin2bcd u_min_bcd (.bin_i(min_q), .bcd_o(min_bcd_o));
`endif
endmodule
